// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin 2:1 mux arbiter.
// These cover the FSM state encodings and the mux select values.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/mux_rtl.sv
// Existing single-bit 2:1 mux cell of the datapath.
// When sel is 1 the output follows a; when sel is 0 it follows b.
module mux_rtl (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? a : b;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select of a 2:1 valid/ready mux.
// A grant lasts one packet, and is cut short after MAX_BURST accepted beats.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              sel,
    output logic              busy
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    state_t           state_reg, state_next;
    logic             sel_reg, sel_next;
    logic             busy_reg, busy_next;
    logic             last_gnt_reg, last_gnt_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic             gnt_valid;

    // Bit DATA_W of each mux lane carries the last flag alongside the data.
    logic [DATA_W:0] mux_a;
    logic [DATA_W:0] mux_b;
    logic [DATA_W:0] mux_y;

    assign mux_a = {a_last, a_data};
    assign mux_b = {b_last, b_data};

    generate
        for (genvar gi = 0; gi < DATA_W + 1; gi++) begin : g_mux
            mux_rtl u_mux (
                .a   (mux_a[gi]),
                .b   (mux_b[gi]),
                .sel (sel_reg),
                .y   (mux_y[gi])
            );
        end
    endgenerate

    assign out_data = mux_y[DATA_W-1:0];
    assign out_last = mux_y[DATA_W];
    assign sel      = sel_reg;
    assign busy     = busy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            sel_reg      <= SEL_B;
            busy_reg     <= 1'b0;
            last_gnt_reg <= SEL_B;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            busy_reg     <= busy_next;
            last_gnt_reg <= last_gnt_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        busy_next     = busy_reg;
        last_gnt_next = last_gnt_reg;
        beat_cnt_next = beat_cnt_reg;
        out_valid     = 1'b0;
        a_ready       = 1'b0;
        b_ready       = 1'b0;
        gnt_valid     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // On a tie, the requester not served most recently wins.
                if (a_valid && (!b_valid || last_gnt_reg == SEL_B)) begin
                    state_next    = ST_GNT_A;
                    sel_next      = SEL_A;
                    last_gnt_next = SEL_A;
                    busy_next     = 1'b1;
                    beat_cnt_next = '0;
                end else if (b_valid) begin
                    state_next    = ST_GNT_B;
                    sel_next      = SEL_B;
                    last_gnt_next = SEL_B;
                    busy_next     = 1'b1;
                    beat_cnt_next = '0;
                end
            end
            ST_GNT_A: begin
                out_valid = a_valid;
                a_ready   = out_ready;
                gnt_valid = a_valid;
            end
            ST_GNT_B: begin
                out_valid = b_valid;
                b_ready   = out_ready;
                gnt_valid = b_valid;
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        endcase

        // sel already points at the granted lane, so mux_y carries its last flag.
        if (gnt_valid && out_ready) begin
            if (beat_cnt_reg != CNT_MAX)
                beat_cnt_next = beat_cnt_reg + 1'b1;
            if (mux_y[DATA_W] || beat_cnt_reg == CNT_MAX - 1'b1) begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios followed by random traffic.
// Every cycle is checked against a behavioural model of owner, tie order and beats taken.
module tb_mux_rr_arbiter;

    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              a_valid = 1'b0;
    logic [DATA_W-1:0] a_data = '0;
    logic              a_last = 1'b0;
    logic              a_ready;
    logic              b_valid = 1'b0;
    logic [DATA_W-1:0] b_data = '0;
    logic              b_last = 1'b0;
    logic              b_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready = 1'b1;
    logic              sel;
    logic              busy;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    int tests  = 0;
    int failed = 0;

    // Pending beats per requester: bit 8 is last, bits 7:0 are data.
    logic [8:0] qa[$];
    logic [8:0] qb[$];
    int         gnt_log[$];

    logic a_en = 1'b1;
    logic b_en = 1'b1;
    logic a_stuck = 1'b0;
    logic b_stuck = 1'b0;
    bit   rnd_mode = 1'b0;
    int   cyc = 0;
    int   stall_lo = -1, stall_hi = -1;
    int   gap_lo = -1, gap_hi = -1;

    // Model: owner 0 = nobody, 1 = A, 2 = B; served = most recently granted.
    int   owner = 0;
    int   served = 2;
    int   taken = 0;
    logic sel_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_gnt(input string tag, input int idx, input int exp);
        int obs;
        obs = (idx < gnt_log.size()) ? gnt_log[idx] : -1;
        chk(tag, obs, exp);
    endtask

    task automatic step();
        logic acc, lst, exp_valid;
        int   nxt;
        if (!rnd_mode) begin
            a_en      = 1'b1;
            b_en      = !(cyc >= gap_lo && cyc <= gap_hi);
            out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
        end
        a_valid = a_en && qa.size() > 0;
        b_valid = b_en && qb.size() > 0;
        a_data = '0; a_last = 1'b0; b_data = '0; b_last = 1'b0;
        if (a_valid) begin a_data = qa[0][7:0]; a_last = qa[0][8]; end
        if (b_valid) begin b_data = qb[0][7:0]; b_last = qb[0][8]; end
        #1;
        exp_valid = (owner == 1) ? a_valid : (owner == 2) ? b_valid : 1'b0;
        chk("out_valid", out_valid, exp_valid);
        chk("a_ready", a_ready, (owner == 1) ? out_ready : 1'b0);
        chk("b_ready", b_ready, (owner == 2) ? out_ready : 1'b0);
        chk("sel", sel, sel_m);
        chk("busy", busy, owner != 0);
        if (exp_valid) begin
            chk("out_data", out_data, (owner == 1) ? a_data : b_data);
            chk("out_last", out_last, (owner == 1) ? a_last : b_last);
        end
        @(posedge clk);
        acc = out_ready && ((owner == 1 && a_valid) || (owner == 2 && b_valid));
        lst = (owner == 1) ? a_last : b_last;
        a_stuck = a_valid && !(acc && owner == 1);
        b_stuck = b_valid && !(acc && owner == 2);
        if (acc && owner == 1) void'(qa.pop_front());
        if (acc && owner == 2) void'(qb.pop_front());
        if (rst) begin
            owner = 0; served = 2; taken = 0; sel_m = 1'b0;
        end else if (owner == 0) begin
            nxt = 0;
            if (a_valid && (!b_valid || served == 2)) nxt = 1;
            else if (b_valid) nxt = 2;
            if (nxt != 0) begin
                owner = nxt; served = nxt; taken = 0; sel_m = (nxt == 1);
                gnt_log.push_back(nxt);
            end
        end else if (acc) begin
            taken++;
            if (lst || taken == MAX_BURST) owner = 0;
        end
        cyc++;
        #1;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((qa.size() > 0 || qb.size() > 0 || owner != 0) && n < bound) begin
            step();
            n++;
        end
        chk("drain_done", qa.size() + qb.size() + ((owner != 0) ? 1 : 0), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    int base;

    initial begin
        // Bring the DUT out of X before the model starts comparing.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single requester: a three-beat packet from A.
        qa.push_back(9'h011); qa.push_back(9'h022); qa.push_back(9'h133);
        base = gnt_log.size();
        drain(30);
        chk_gnt("single_gnt", base, 1);

        // Tie after reset: grants alternate A, B, A, B.
        do_reset();
        qa.push_back(9'h1a1); qa.push_back(9'h1a2);
        qb.push_back(9'h1b1); qb.push_back(9'h1b2);
        base = gnt_log.size();
        drain(30);
        chk_gnt("tie_0", base, 1);
        chk_gnt("tie_1", base + 1, 2);
        chk_gnt("tie_2", base + 2, 1);
        chk_gnt("tie_3", base + 3, 2);

        // Forced release: six A beats, last only on the sixth, with B waiting.
        for (int i = 1; i <= 6; i++) qa.push_back({(i == 6), 8'(8'h40 + i)});
        qb.push_back(9'h0c1); qb.push_back(9'h1c2);
        base = gnt_log.size();
        drain(40);
        chk_gnt("burst_0", base, 1);
        chk_gnt("burst_1", base + 1, 2);
        chk_gnt("burst_2", base + 2, 1);

        // Backpressure: out_ready low for three cycles mid-packet.
        cyc = 0; stall_lo = 2; stall_hi = 4;
        for (int i = 1; i <= 4; i++) qa.push_back({(i == 4), 8'(8'h50 + i)});
        drain(30);
        stall_lo = -1; stall_hi = -1;

        // Valid gap: B drops valid for two cycles while A requests.
        cyc = 0; gap_lo = 2; gap_hi = 3;
        qa.push_back(9'h161);
        for (int i = 1; i <= 4; i++) qb.push_back({(i == 4), 8'(8'h70 + i)});
        base = gnt_log.size();
        drain(30);
        chk_gnt("gap_0", base, 2);
        chk_gnt("gap_1", base + 1, 1);
        gap_lo = -1; gap_hi = -1;

        // Reset on beat two of an A packet, then a tie must go to A.
        cyc = 0;
        for (int i = 1; i <= 4; i++) qa.push_back({(i == 4), 8'(8'h80 + i)});
        for (int i = 0; i < 3; i++) begin
            rst = (i == 2);
            step();
        end
        rst = 1'b0;
        qa.delete(); qb.delete();
        step();
        qa.push_back(9'h191); qb.push_back(9'h192);
        base = gnt_log.size();
        drain(20);
        chk_gnt("rst_tie", base, 1);

        // Random traffic with random gaps and backpressure.
        rnd_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (qa.size() < 3 && $urandom_range(0, 3) == 0) begin
                int len = $urandom_range(1, 6);
                for (int k = 1; k <= len; k++) qa.push_back({(k == len), 8'($urandom)});
            end
            if (qb.size() < 3 && $urandom_range(0, 3) == 0) begin
                int len = $urandom_range(1, 6);
                for (int k = 1; k <= len; k++) qb.push_back({(k == len), 8'($urandom)});
            end
            a_en      = a_stuck ? 1'b1 : ($urandom_range(0, 3) != 0);
            b_en      = b_stuck ? 1'b1 : ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rnd_mode = 1'b0;
        drain(300);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
